// File: rtl/jt6295_enc_if.sv
// Sample-in / byte-out handshake bundle for the jt6295_enc ADPCM encoder.
// master = sample producer and byte consumer; slave = the encoder.
interface jt6295_enc_if;
    logic signed [11:0] pcm_in;
    logic               pcm_valid;
    logic               pcm_ready;
    logic        [7:0]  dout;
    logic               dout_valid;
    logic               dout_ready;

    modport master (output pcm_in, pcm_valid, dout_ready,
                    input  pcm_ready, dout, dout_valid);
    modport slave  (input  pcm_in, pcm_valid, dout_ready,
                    output pcm_ready, dout, dout_valid);
endinterface

// File: rtl/jt6295_enc.sv
// OKI 4-bit ADPCM encoder tracking the jt6295 decoder predictor; packs two nibbles per byte.
// Optional macro JT6295_ENC_RECON_EN adds recon/recon_valid outputs carrying the updated predictor.
module jt6295_enc #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic          flush,
    jt6295_enc_if.slave   bus,
    output logic [AW-1:0] byte_cnt,
    output logic          busy
`ifdef JT6295_ENC_RECON_EN
    ,
    output logic signed [11:0] recon,
    output logic               recon_valid
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, QUANT = 2'd1, UPD = 2'd2} state_t;

    function automatic logic [10:0] step_lut(input logic [5:0] i);
        case (i)
            6'd0:  step_lut = 11'd16;   6'd1:  step_lut = 11'd17;   6'd2:  step_lut = 11'd19;
            6'd3:  step_lut = 11'd21;   6'd4:  step_lut = 11'd23;   6'd5:  step_lut = 11'd25;
            6'd6:  step_lut = 11'd28;   6'd7:  step_lut = 11'd31;   6'd8:  step_lut = 11'd34;
            6'd9:  step_lut = 11'd37;   6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
            6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
            6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
            6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
            6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
            6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
            6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
            6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
            6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
            6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
            6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
            6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
            6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
            6'd48: step_lut = 11'd1552;
            default: step_lut = 11'd1552;
        endcase
    endfunction

    function automatic logic signed [6:0] idx_adj(input logic [2:0] c);
        case (c)
            3'd4:    idx_adj = 7'sd2;
            3'd5:    idx_adj = 7'sd4;
            3'd6:    idx_adj = 7'sd6;
            3'd7:    idx_adj = 7'sd8;
            default: idx_adj = -7'sd1;
        endcase
    endfunction

    state_t             state_q;
    logic signed [11:0] sample_q, pred_q, pred_d;
    logic        [5:0]  idx_q, idx_d;
    logic        [3:0]  code_q, code_d, hi_q;
    logic               half_q, flush_pend_q;
    logic        [7:0]  dout_q;
    logic               dout_valid_q;
    logic [AW-1:0]      byte_cnt_q;
    logic signed [11:0] recon_q;
    logic               recon_valid_q;

    logic signed [12:0] diff_s;
    logic        [11:0] mag_s, m1_s, m2_s, st_s;
    logic               b2_s, b1_s, b0_s;
    logic        [12:0] delta_s;
    logic signed [13:0] sum_s;
    logic signed [6:0]  idx_sum_s;
    logic               flush_go_s;

    // Quantise the prediction error against the current step.
    always_comb begin
        st_s   = {1'b0, step_lut(idx_q)};
        diff_s = {sample_q[11], sample_q} - {pred_q[11], pred_q};
        mag_s  = diff_s[12] ? 12'(-diff_s) : diff_s[11:0];
        b2_s   = mag_s >= st_s;
        m1_s   = b2_s ? mag_s - st_s : mag_s;
        b1_s   = m1_s >= (st_s >> 1);
        m2_s   = b1_s ? m1_s - (st_s >> 1) : m1_s;
        b0_s   = m2_s >= (st_s >> 2);
        code_d = {diff_s[12], b2_s, b1_s, b0_s};
    end

    // Reconstruct the predictor and step index exactly as the decoder does.
    always_comb begin
        delta_s = {1'b0, st_s >> 3}
                + (code_q[0] ? {1'b0, st_s >> 2} : 13'd0)
                + (code_q[1] ? {1'b0, st_s >> 1} : 13'd0)
                + (code_q[2] ? {1'b0, st_s}      : 13'd0);
        sum_s = code_q[3] ? ({{2{pred_q[11]}}, pred_q} - $signed({1'b0, delta_s}))
                          : ({{2{pred_q[11]}}, pred_q} + $signed({1'b0, delta_s}));
        if (sum_s > 14'sd2047) begin
            pred_d = 12'sd2047;
        end else if (sum_s < -14'sd2048) begin
            pred_d = -12'sd2048;
        end else begin
            pred_d = sum_s[11:0];
        end
        idx_sum_s = $signed({1'b0, idx_q}) + idx_adj(code_q[2:0]);
        if (idx_sum_s < 7'sd0) begin
            idx_d = 6'd0;
        end else if (idx_sum_s > 7'sd48) begin
            idx_d = 6'd48;
        end else begin
            idx_d = idx_sum_s[5:0];
        end
        flush_go_s = (flush_pend_q || flush) && (state_q == IDLE) && !dout_valid_q;
    end

    // Encoder FSM, packer and output handshake; start behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || (cen && start)) begin
            state_q       <= IDLE;
            sample_q      <= 12'sd0;
            pred_q        <= 12'sd0;
            idx_q         <= 6'd0;
            code_q        <= 4'd0;
            hi_q          <= 4'd0;
            half_q        <= 1'b0;
            flush_pend_q  <= 1'b0;
            dout_q        <= 8'd0;
            dout_valid_q  <= 1'b0;
            byte_cnt_q    <= '0;
            recon_q       <= 12'sd0;
            recon_valid_q <= 1'b0;
        end else if (cen) begin
            recon_valid_q <= 1'b0;
            if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
                byte_cnt_q   <= byte_cnt_q + 1'b1;
            end
            if (flush) begin
                flush_pend_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (flush_go_s) begin
                        flush_pend_q <= 1'b0;
                        if (half_q) begin
                            dout_q       <= {hi_q, 4'h0};
                            dout_valid_q <= 1'b1;
                            half_q       <= 1'b0;
                        end
                    end
                    if (bus.pcm_valid && !dout_valid_q) begin
                        sample_q <= bus.pcm_in;
                        state_q  <= QUANT;
                    end
                end
                QUANT: begin
                    code_q  <= code_d;
                    state_q <= UPD;
                end
                UPD: begin
                    pred_q        <= pred_d;
                    idx_q         <= idx_d;
                    recon_q       <= pred_d;
                    recon_valid_q <= 1'b1;
                    if (half_q) begin
                        dout_q       <= {hi_q, code_q};
                        dout_valid_q <= 1'b1;
                        half_q       <= 1'b0;
                    end else begin
                        hi_q   <= code_q;
                        half_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pcm_ready  = (state_q == IDLE) && !dout_valid_q && cen;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign byte_cnt       = byte_cnt_q;
    assign busy           = (state_q != IDLE) || half_q;
`ifdef JT6295_ENC_RECON_EN
    assign recon       = recon_q;
    assign recon_valid = recon_valid_q;
`endif

endmodule

// File: tb/tb_jt6295_enc.sv
// Self-checking bench for jt6295_enc: directed scenarios plus a randomized run against an
// integer ADPCM reference model with an expected-byte queue.
module tb_jt6295_enc;
    logic clk, rst, cen, start, flush;
    logic [17:0] byte_cnt;
    logic busy;
    jt6295_enc_if bus ();

    jt6295_enc #(.AW(18)) dut (
        .clk(clk), .rst(rst), .cen(cen), .start(start), .flush(flush),
        .bus(bus), .byte_cnt(byte_cnt), .busy(busy)
    );

    int n_cmp = 0, n_fail = 0;
    int cen_rand = 0, rdy_rand = 0;
    int STEP [49] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,
                      143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,
                      796,876,963,1060,1166,1282,1411,1552};
    int m_pred, m_idx, m_half, m_hi, m_cnt;
    int exp_q [$];
    logic [7:0] last_dout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_pred = 0; m_idx = 0; m_half = 0; m_hi = 0; m_cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_nibble(input int n);
        if (m_half == 0) begin
            m_hi = n; m_half = 1;
        end else begin
            exp_q.push_back(m_hi * 16 + n); m_half = 0;
        end
    endtask

    task automatic model_flush();
        if (m_half != 0) begin
            exp_q.push_back(m_hi * 16); m_half = 0;
        end
    endtask

    // Greedy three-threshold quantiser followed by the decoder's reconstruction.
    task automatic model_sample(input int s);
        int d, m, st, mag, rec;
        int thr [3];
        d = s - m_pred;
        m = (d < 0) ? -d : d;
        st = STEP[m_idx];
        thr = '{st, st / 2, st / 4};
        mag = 0;
        rec = st / 8;
        for (int k = 0; k < 3; k++) begin
            if (m >= thr[k]) begin
                mag += (4 >> k);
                m -= thr[k];
                rec += thr[k];
            end
        end
        m_pred = (d < 0) ? m_pred - rec : m_pred + rec;
        if (m_pred > 2047) m_pred = 2047;
        if (m_pred < -2048) m_pred = -2048;
        m_idx += (mag < 4) ? -1 : (mag - 3) * 2;
        if (m_idx < 0) m_idx = 0;
        if (m_idx > 48) m_idx = 48;
        model_nibble(((d < 0) ? 8 : 0) + mag);
    endtask

    // Random cen / dout_ready, updated mid-cycle so they are stable at the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cen = (cen_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rdy_rand != 0) bus.dout_ready = $urandom_range(0, 1) != 0;
        end
    end

    // Byte monitor: any transfer at the coming edge must match the model queue head.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (!rst && cen && !start && bus.dout_valid && bus.dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("byte_unexpected", {31'd0, bus.dout_valid}, 32'd0);
                end else begin
                    chk("byte", {24'd0, bus.dout}, exp_q.pop_front());
                end
                m_cnt++;
                last_dout = bus.dout;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic send_sample(input int s);
        int n;
        logic [31:0] sv;
        sv = s;
        bus.pcm_in = sv[11:0];
        bus.pcm_valid = 1'b1;
        n = 0;
        while (!bus.pcm_ready && n < 500) begin step(); n++; end
        if (n >= 500) chk("ready_timeout", {31'd0, bus.pcm_ready}, 32'd1);
        step();
        bus.pcm_valid = 1'b0;
        model_sample(s);
    endtask

    task automatic pulse_flush();
        while (!cen) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_flush();
    endtask

    task automatic pulse_start();
        while (!cen) step();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || bus.dout_valid) && n < 2000) begin step(); n++; end
        if (n >= 2000) chk("drain_timeout", {31'd0, busy | bus.dout_valid}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        model_clear();
        step();
    endtask

    initial begin
        logic [7:0] held;
        int n, s;
        rst = 1'b1; cen = 1'b1; start = 1'b0; flush = 1'b0;
        bus.pcm_in = 12'd0; bus.pcm_valid = 1'b0; bus.dout_ready = 1'b1;
        model_clear();
        repeat (3) step();
        chk("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("rst_pcm_ready", {31'd0, bus.pcm_ready}, 32'd1);
        chk("rst_byte_cnt", {14'd0, byte_cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", {24'd0, bus.dout}, 32'd0);
        rst = 1'b0;
        step();

        send_sample(100);
        send_sample(100);
        drain();
        chk("pair_byte", {24'd0, last_dout}, 32'h77);
        chk("pair_cnt", {14'd0, byte_cnt}, 32'd1);

        do_reset();
        send_sample(-100);
        pulse_flush();
        drain();
        chk("flush_byte", {24'd0, last_dout}, 32'hF0);
        chk("flush_cnt", {14'd0, byte_cnt}, 32'd1);
        pulse_flush();
        repeat (4) step();
        chk("flush2_cnt", {14'd0, byte_cnt}, 32'd1);
        chk("flush2_valid", {31'd0, bus.dout_valid}, 32'd0);

        do_reset();
        for (int i = 0; i < 40; i++) send_sample(2047);
        drain();
        chk("sat_cnt", {14'd0, byte_cnt}, 32'd20);

        do_reset();
        bus.dout_ready = 1'b0;
        send_sample(300);
        send_sample(-300);
        n = 0;
        while (!bus.dout_valid && n < 20) begin step(); n++; end
        held = bus.dout;
        for (int i = 0; i < 20; i++) begin
            chk("hold_ready", {31'd0, bus.pcm_ready}, 32'd0);
            chk("hold_dout", {24'd0, bus.dout}, {24'd0, held});
            chk("hold_valid", {31'd0, bus.dout_valid}, 32'd1);
            step();
        end
        bus.dout_ready = 1'b1;
        step();
        chk("hold_release_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("hold_release_cnt", {14'd0, byte_cnt}, 32'd1);
        chk("hold_release_ready", {31'd0, bus.pcm_ready}, 32'd1);

        do_reset();
        send_sample(500);
        send_sample(-700);
        pulse_start();
        step();
        chk("start_busy", {31'd0, busy}, 32'd0);
        chk("start_valid", {31'd0, bus.dout_valid}, 32'd0);
        chk("start_cnt", {14'd0, byte_cnt}, 32'd0);
        send_sample(0);
        send_sample(0);
        drain();
        chk("start_zero_byte", {24'd0, last_dout}, 32'h08);
        chk("start_zero_cnt", {14'd0, byte_cnt}, 32'd1);

        do_reset();
        cen_rand = 1; rdy_rand = 1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       s = 2047;
                1:       s = -2048;
                default: s = int'($urandom_range(0, 4095)) - 2048;
            endcase
            send_sample(s);
            if ($urandom_range(0, 7) == 0) pulse_flush();
        end
        pulse_flush();
        drain();
        cen_rand = 0; rdy_rand = 0;
        step();
        chk("rand_cnt", {14'd0, byte_cnt}, m_cnt);
        chk("rand_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
